// File: rtl/result_copy_scheduler_pkg.sv
// Shared types for the result copy scheduler: FSM states, latched job record, address width.
package result_copy_pkg;

   localparam int RESULT_ADDR_W = 64;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ARB,
      S_ISSUE,
      S_WAIT_ACK,
      S_WAIT_DONE,
      S_NEXT
   } sched_state_t;

   typedef struct packed {
      logic [31:0]              offset;
      logic [31:0]              words;
      logic [RESULT_ADDR_W-1:0] memory_addr;
   } copy_job_t;

endpackage

// File: rtl/result_copy_scheduler_if.sv
// Requester-side and engine-side signals of the result copy scheduler.
interface result_copy_scheduler_if #(
   parameter int NUM_REQ = 4
);
   import result_copy_pkg::*;

   localparam int IDX_W = $clog2(NUM_REQ);

   // Handshakes: req_kick[i] is a one-cycle post accepted only while req_busy[i] is low;
   // req_done[i] pulses once per accepted job. copy_kick is a one-cycle request; the engine
   // acknowledges by raising copy_busy on a later cycle and completes the chunk by dropping it.
   logic [NUM_REQ-1:0]               req_kick;
   logic [NUM_REQ*32-1:0]            req_offset;
   logic [NUM_REQ*32-1:0]            req_words;
   logic [NUM_REQ*RESULT_ADDR_W-1:0] req_memory_addr;
   logic [NUM_REQ-1:0]               req_busy;
   logic [NUM_REQ-1:0]               req_done;
   logic                             copy_kick;
   logic                             copy_busy;
   logic [31:0]                      copy_offset;
   logic [31:0]                      copy_words;
   logic [RESULT_ADDR_W-1:0]         copy_memory_addr;
   logic [IDX_W-1:0]                 grant_id;

   modport master (
      input  req_kick, req_offset, req_words, req_memory_addr, copy_busy,
      output req_busy, req_done, copy_kick, copy_offset, copy_words, copy_memory_addr, grant_id
   );

   modport slave (
      output req_kick, req_offset, req_words, req_memory_addr, copy_busy,
      input  req_busy, req_done, copy_kick, copy_offset, copy_words, copy_memory_addr, grant_id
   );

endinterface

// File: rtl/result_copy_scheduler_rr_arbiter.sv
// Round-robin pick: lowest requesting index at or after ptr, otherwise lowest overall.
module rr_arbiter #(
   parameter int NUM_REQ = 4,
   localparam int IDX_W = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   input  logic               en,
   output logic [NUM_REQ-1:0] gnt,
   output logic [IDX_W-1:0]   idx
);

   logic found;

   always_comb begin
      found = 1'b0;
      idx   = '0;
      for (int j = 0; j < NUM_REQ; j++) begin
         if (en && !found && req[j] && (IDX_W'(j) >= ptr)) begin
            found = 1'b1;
            idx   = IDX_W'(j);
         end
      end
      // Second pass only matters when nothing at or above ptr was requesting (wrap-around).
      for (int j = 0; j < NUM_REQ; j++) begin
         if (en && !found && req[j]) begin
            found = 1'b1;
            idx   = IDX_W'(j);
         end
      end
      gnt = found ? (NUM_REQ'(1) << idx) : '0;
   end

endmodule

// File: rtl/result_copy_scheduler.sv
// Shares one copy engine among NUM_REQ requesters: round-robin job selection,
// chunking into at most CHUNK_WORDS per engine kick, per-requester completion pulse.
module result_copy_scheduler
   import result_copy_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int CHUNK_WORDS = 1024,
   parameter int WORD_BYTES  = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   result_copy_scheduler_if.master bus,
   output sched_state_t            state_dbg
);

   localparam int                       IDX_W = $clog2(NUM_REQ);
   localparam logic [31:0]              CHUNK = 32'(CHUNK_WORDS);
   localparam logic [RESULT_ADDR_W-1:0] WB    = RESULT_ADDR_W'(WORD_BYTES);

   sched_state_t             state, state_nx;
   copy_job_t                slot [NUM_REQ];
   logic [NUM_REQ-1:0]       pend;
   logic [IDX_W-1:0]         rr_ptr, grant_q;
   logic [31:0]              cur_off, remaining, chunk;
   logic [RESULT_ADDR_W-1:0] cur_addr;
   logic [NUM_REQ-1:0]       arb_gnt, done_vec;
   logic [IDX_W-1:0]         arb_idx;

   rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
      .req (pend),
      .ptr (rr_ptr),
      .en  (state == S_ARB),
      .gnt (arb_gnt),
      .idx (arb_idx)
   );

   assign chunk = (remaining > CHUNK) ? CHUNK : remaining;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      done_vec = '0;
      case (state)
         S_IDLE:      if (|pend) state_nx = S_ARB;
         S_ARB: begin
            // Zero-length jobs complete straight from arbitration without touching the engine.
            if (slot[arb_idx].words == 32'd0) begin
               done_vec = arb_gnt;
               state_nx = S_IDLE;
            end else begin
               state_nx = S_ISSUE;
            end
         end
         S_ISSUE:     state_nx = S_WAIT_ACK;
         S_WAIT_ACK:  if (bus.copy_busy) state_nx = S_WAIT_DONE;
         S_WAIT_DONE: if (!bus.copy_busy) state_nx = S_NEXT;
         S_NEXT: begin
            if (remaining == chunk) begin
               done_vec = NUM_REQ'(1) << grant_q;
               state_nx = S_IDLE;
            end else begin
               state_nx = S_ISSUE;
            end
         end
         default:     state_nx = S_IDLE;
      endcase
   end

   // Job slots: a post is taken only into an idle slot; completion frees it one cycle later.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         pend <= '0;
         for (int i = 0; i < NUM_REQ; i++) slot[i] <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (done_vec[i]) begin
               pend[i] <= 1'b0;
            end else if (bus.req_kick[i] && !pend[i]) begin
               pend[i]             <= 1'b1;
               slot[i].offset      <= bus.req_offset[i*32 +: 32];
               slot[i].words       <= bus.req_words[i*32 +: 32];
               slot[i].memory_addr <= bus.req_memory_addr[i*RESULT_ADDR_W +: RESULT_ADDR_W];
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr    <= '0;
         grant_q   <= '0;
         cur_off   <= '0;
         remaining <= '0;
         cur_addr  <= '0;
      end else if (state == S_ARB) begin
         grant_q   <= arb_idx;
         rr_ptr    <= (arb_idx == IDX_W'(NUM_REQ - 1)) ? '0 : arb_idx + IDX_W'(1);
         cur_off   <= slot[arb_idx].offset;
         remaining <= slot[arb_idx].words;
         cur_addr  <= slot[arb_idx].memory_addr;
      end else if (state == S_NEXT) begin
         remaining <= remaining - chunk;
         cur_off   <= cur_off + chunk;
         cur_addr  <= cur_addr + RESULT_ADDR_W'(chunk) * WB;
      end
   end

   assign bus.req_busy         = pend;
   assign bus.req_done         = done_vec;
   assign bus.copy_kick        = (state == S_ISSUE);
   assign bus.copy_offset      = cur_off;
   assign bus.copy_words       = chunk;
   assign bus.copy_memory_addr = cur_addr;
   assign bus.grant_id         = grant_q;
   assign state_dbg            = state;

endmodule

// File: doc/result_copy_scheduler.md
Name: result_copy_scheduler

Overview:
- Shares one simple_result_copy engine among NUM_REQ requesters, e.g. per-bank wordcount result flushers.
- Each requester posts a copy job: a result-memory word offset, a word count and a host memory byte address.
- The scheduler arbitrates round-robin between pending jobs and splits each job into chunks of at most CHUNK_WORDS.
- It kicks the engine once per chunk and reports completion per requester.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- CHUNK_WORDS, 1024, maximum words per engine kick (power of two).
- WORD_BYTES, 8, bytes per result word; memory_addr advances by words*WORD_BYTES.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_kick  in  NUM_REQ  per-requester 1-cycle job post pulse.
- req_offset  in  NUM_REQ*32  job start word offset, sampled on req_kick.
- req_words  in  NUM_REQ*32  job length in words, sampled on req_kick.
- req_memory_addr  in  NUM_REQ*64  job host byte address, sampled on req_kick.
- req_busy  out  NUM_REQ  requester job pending or in progress.
- req_done  out  NUM_REQ  1-cycle pulse when that job has finished.
- copy_kick  out  1  1-cycle kick to the copy engine.
- copy_busy  in  1  engine busy.
- copy_offset  out  32  chunk word offset.
- copy_words  out  32  chunk length.
- copy_memory_addr  out  64  chunk host byte address.
- grant_id  out  $clog2(NUM_REQ)  index of the requester currently being served.

Behaviour:
- Reset (async, reset_n=0):
  - All outputs go to 0: req_busy, req_done, copy_kick, copy_offset, copy_words, copy_memory_addr, grant_id.
  - All pending jobs are dropped, the round-robin pointer is 0 and the state is IDLE.
  - Asserting reset mid-job aborts it with no req_done.
- Job posting:
  - req_kick[i] with req_busy[i]=0 latches offset, words and addr into slot i.
  - req_busy[i] rises the next cycle.
  - req_kick[i] while req_busy[i]=1 is ignored; the slot is unchanged.
- State machine: IDLE, ARB, ISSUE, WAIT_ACK, WAIT_DONE, NEXT.
  - IDLE: if any slot is pending, go to ARB.
  - ARB (1 cycle):
    - Grant the first pending slot at or after rr_ptr, wrapping; set grant_id.
    - rr_ptr becomes grant+1 mod NUM_REQ.
    - Load cur_off, cur_addr and remaining from the slot.
    - If remaining==0, pulse req_done[grant], clear req_busy[grant] and return to IDLE. The engine is not kicked.
  - ISSUE:
    - copy_words = min(remaining, CHUNK_WORDS), copy_offset = cur_off, copy_memory_addr = cur_addr.
    - copy_kick=1 for exactly this one cycle; go to WAIT_ACK.
    - The copy_* values hold stable from ISSUE until leaving WAIT_DONE.
  - WAIT_ACK: wait for copy_busy=1, then go to WAIT_DONE. A busy already high in the ISSUE cycle does not count.
  - WAIT_DONE: wait for copy_busy=0, then go to NEXT.
  - NEXT:
    - remaining -= copy_words; cur_off += copy_words (mod 2^32); cur_addr += copy_words*WORD_BYTES (64-bit, mod 2^64).
    - If remaining != 0, go to ISSUE. The same requester keeps the engine; there is no preemption between chunks.
    - Otherwise, pulse req_done[grant], clear req_busy[grant] in the same cycle, and go to IDLE.
- Minimum gap between successive copy_kick pulses is 4 cycles.
- A requester may re-post on the cycle after its req_done.
- A new req_kick for another slot during a job is latched and served after the current job.
- Simultaneous req_kick on several slots all latch. Service order is round-robin from rr_ptr.

Decomposition:
- Package result_copy_pkg holds:
  - the sched_state_t enum;
  - the copy_job_t struct (offset 32, words 32, memory_addr 64);
  - localparam RESULT_ADDR_W=64.
- Sub-module rr_arbiter (NUM_REQ): inputs are request vector, pointer and enable; outputs are one-hot grant and index.

Test Plan:
- Single job: slot0 offset=0, words=2058, addr=0xabadcafe_deadbeef, CHUNK_WORDS=1024, engine busy 5 cycles per kick.
  - Expect 3 kicks: (0, 1024, 0xabadcafe_deadbeef), (1024, 1024, +0x2000), (2048, 10, +0x4000).
  - req_done[0] pulses once after the third busy fall.
- Slots 1 and 3 kicked in the same cycle, 100 words each, rr_ptr=0: slot1 is served fully before slot3, and grant_id reads 1 then 3.
- Zero length: words=0 on slot2 -> no copy_kick, req_done[2] exactly 2 cycles after the kick, req_busy[2] low afterward.
- Re-kick while busy: a second req_kick[0] with words=7 during slot0's job is ignored; only the original job's chunks are issued.
- Offset wrap: offset=0xFFFF_FC00, words=2048 -> second chunk copy_offset=0x0000_0000.
- Reset mid-job: reset_n low while in WAIT_DONE -> all outputs 0 immediately; after release, no req_done and no further kicks until a new req_kick.
